// File: rtl/tx_request_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ edge-triggered requesters.
// Optional sticky overrun flags are built when TX_ARB_OVERRUN_EN is defined.
module tx_request_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [N_REQ-1:0]          i_req_level,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic                      i_tx_busy,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    output logic [N_REQ-1:0]          o_grant,
`ifdef TX_ARB_OVERRUN_EN
    output logic [N_REQ-1:0]          o_overrun,
`endif
    output logic [N_REQ-1:0]          o_pending
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] TIMEOUT = 4'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              r_state, w_state_next;
    logic [N_REQ-1:0]    r_prev, r_pending, w_edge, w_clear;
    logic [DATA_W-1:0]   r_hold [N_REQ];
    logic [PW-1:0]       r_ptr, r_sel, w_sel, w_idx;
    logic                w_found;
    logic [3:0]          r_cnt, w_cnt_next;
    logic [N_REQ-1:0]    r_grant;
    logic [DATA_W-1:0]   r_tx_data;

    assign w_edge  = i_req_level & ~r_prev;
    assign w_clear = (r_state == START) ? (N_REQ'(1) << r_sel) : '0;

    // A new edge in the same cycle as the clear keeps the request pending.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= i_req_level;
            r_pending <= (r_pending & ~w_clear) | w_edge;
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hold
            always_ff @(posedge i_clock) begin
                if (i_reset)
                    r_hold[gi] <= '0;
                else if (w_edge[gi])
                    r_hold[gi] <= i_req_data[gi*DATA_W +: DATA_W];
            end
        end
    endgenerate

    // First pending requester at or above r_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found)
                    w_state_next = START;
            end
            START: begin
                w_state_next = WAIT_BUSY;
                w_cnt_next   = '0;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_next = WAIT_DONE;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                    if (w_cnt_next == TIMEOUT)
                        w_state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_grant   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && w_found) begin
                r_sel     <= w_sel;
                r_grant   <= N_REQ'(1) << w_sel;
                r_tx_data <= r_hold[w_sel];
            end
            if (r_state != IDLE && w_state_next == IDLE) begin
                r_grant <= '0;
                r_ptr   <= (r_sel == PW'(N_REQ - 1)) ? '0 : r_sel + PW'(1);
            end
        end
    end

`ifdef TX_ARB_OVERRUN_EN
    logic [N_REQ-1:0] r_overrun;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_overrun <= '0;
        else
            r_overrun <= r_overrun | (w_edge & r_pending & ~w_clear);
    end

    assign o_overrun = r_overrun;
`endif

    assign o_tx_start = (r_state == START);
    assign o_tx_data  = r_tx_data;
    assign o_grant    = r_grant;
    assign o_pending  = r_pending;

endmodule

// File: tb/tb_tx_request_arbiter.sv
// Directed self-checking bench for tx_request_arbiter with a simple transmitter busy model.
module tb_tx_request_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lvl;
    logic [31:0] dat;
    logic        busy = 1'b0;
    logic        start;
    logic [7:0]  txd;
    logic [3:0]  grant;
    logic [3:0]  pend;
`ifdef TX_ARB_OVERRUN_EN
    logic [3:0]  ovr;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_n = 0;
    logic [7:0] log_data  [64];
    logic [3:0] log_grant [64];
    int         log_cyc   [64];
    bit model_en = 1'b1;
    int busy_left = 0;
    bit arm = 1'b0;

    always #5 clk = ~clk;

    tx_request_arbiter #(.N_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(3)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_level (lvl),
        .i_req_data  (dat),
        .i_tx_busy   (busy),
        .o_tx_start  (start),
        .o_tx_data   (txd),
        .o_grant     (grant),
`ifdef TX_ARB_OVERRUN_EN
        .o_overrun   (ovr),
`endif
        .o_pending   (pend)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises one cycle after a start and stays high 10 cycles.
    always @(negedge clk) begin
        if (rst || !model_en) begin
            busy = 1'b0; busy_left = 0; arm = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy = 1'b0;
        end else if (arm) begin
            arm = 1'b0; busy = 1'b1; busy_left = 10;
        end
        if (start === 1'b1) begin
            if (start_n < 64) begin
                log_data[start_n] = txd; log_grant[start_n] = grant; log_cyc[start_n] = cyc;
            end
            $display("start #%0d cyc=%0d grant=%b data=%h", start_n, cyc, grant, txd);
            start_n++;
            if (!rst && model_en) arm = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lvl = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n;
        n = 0;
        while (n < bound && !(grant == 4'b0 && pend == 4'b0 && busy == 1'b0 && start == 1'b0)) begin
            step(); n++;
        end
        total++;
        if (n >= bound) begin bad++; $display("FAIL wait_quiet timeout after %0d cycles grant=%b pend=%b", n, grant, pend); end
    endtask

    task automatic test_reset();
        rst = 1'b1; lvl = 4'b1111; dat = 32'hFFFF_FFFF;
        step(); step();
        total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", start); end
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (txd !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", txd); end
        total++; if (pend !== 4'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pend); end
`ifdef TX_ARB_OVERRUN_EN
        total++; if (ovr !== 4'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0000", ovr); end
`endif
        lvl = '0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int base, n;
        bit stable;
        do_reset(); base = start_n;
        dat = 32'h0041_0000; lvl = 4'b0100;
        step();
        total++; if (pend !== 4'b0100) begin bad++; $display("FAIL single_pend_set got=%b exp=0100", pend); end
        step();
        total++; if (start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", start); end
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", grant); end
        total++; if (txd !== 8'h41) begin bad++; $display("FAIL single_data got=%h exp=41", txd); end
        step();
        total++; if (start !== 1'b0) begin bad++; $display("FAIL single_start_len got=%b exp=0", start); end
        total++; if (pend !== 4'b0) begin bad++; $display("FAIL single_pend_clr got=%b exp=0000", pend); end
        n = 0; stable = 1'b1;
        while (n < 40) begin
            step(); n++;
            if (grant == 4'b0) break;
            if (grant !== 4'b0100 || txd !== 8'h41) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL single_stable got=0 exp=1"); end
        total++; if (n != 11) begin bad++; $display("FAIL single_idle_delay got=%0d exp=11", n); end
        total++; if (start_n - base != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", start_n - base); end
        lvl = '0;
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int base;
        do_reset(); base = start_n;
        dat = {8'h13, 8'h12, 8'h11, 8'h10}; lvl = 4'b1111;
        step(); lvl = '0;
        wait_quiet(200);
        total++; if (start_n - base != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", start_n - base); end
        for (int i = 0; i < 4; i++) begin
            total++; if (log_grant[base+i] !== 4'(1 << i)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, log_grant[base+i], 4'(1 << i)); end
            total++; if (log_data[base+i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", i, log_data[base+i], 8'(8'h10 + i)); end
        end
        for (int i = 1; i < 4; i++) begin
            total++; if (log_cyc[base+i] - log_cyc[base+i-1] != 13) begin bad++; $display("FAIL rr_turnaround%0d got=%0d exp=13", i, log_cyc[base+i] - log_cyc[base+i-1]); end
        end
        for (int pass = 0; pass < 2; pass++) begin
            base = start_n;
            dat = (pass == 0) ? {8'hA3, 16'h0000, 8'hA0} : {8'hB3, 16'h0000, 8'hB0};
            lvl = 4'b1001;
            step(); lvl = '0;
            wait_quiet(200);
            total++; if (start_n - base != 2) begin bad++; $display("FAIL rr_wrap%0d_count got=%0d exp=2", pass, start_n - base); end
            total++; if (log_grant[base] !== 4'b0001 || log_grant[base+1] !== 4'b1000) begin bad++; $display("FAIL rr_wrap%0d_order got=%b,%b exp=0001,1000", pass, log_grant[base], log_grant[base+1]); end
            total++; if (log_data[base] !== dat[7:0] || log_data[base+1] !== dat[31:24]) begin bad++; $display("FAIL rr_wrap%0d_data got=%h,%h exp=%h,%h", pass, log_data[base], log_data[base+1], dat[7:0], dat[31:24]); end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_overwrite();
        int base;
        do_reset(); base = start_n;
        dat = 32'h0000_0030; lvl = 4'b0001;
        step(); lvl = '0;
        step(); step();
        dat[15:8] = 8'h55; lvl = 4'b0010;
        step(); lvl = '0;
        step();
        dat[15:8] = 8'h66; lvl = 4'b0010;
        step(); lvl = '0;
        total++; if (pend !== 4'b0010) begin bad++; $display("FAIL ovw_pending got=%b exp=0010", pend); end
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL ovw_owner got=%b exp=0001", grant); end
`ifdef TX_ARB_OVERRUN_EN
        total++; if (ovr !== 4'b0010) begin bad++; $display("FAIL ovw_overrun got=%b exp=0010", ovr); end
`endif
        wait_quiet(100);
        total++; if (start_n - base != 2) begin bad++; $display("FAIL ovw_count got=%0d exp=2", start_n - base); end
        total++; if (log_data[base] !== 8'h30) begin bad++; $display("FAIL ovw_first_data got=%h exp=30", log_data[base]); end
        total++; if (log_grant[base+1] !== 4'b0010 || log_data[base+1] !== 8'h66) begin bad++; $display("FAIL ovw_last_wins got=%b/%h exp=0010/66", log_grant[base+1], log_data[base+1]); end
`ifdef TX_ARB_OVERRUN_EN
        total++; if (ovr !== 4'b0010) begin bad++; $display("FAIL ovw_sticky got=%b exp=0010", ovr); end
`endif
        $display("test_overwrite done");
    endtask

    task automatic test_timeout();
        int base;
        do_reset(); model_en = 1'b0; base = start_n;
        dat = 32'h0072_7100; lvl = 4'b0110;
        step();
        total++; if (pend !== 4'b0110) begin bad++; $display("FAIL to_pending got=%b exp=0110", pend); end
        lvl = '0;
        step();
        total++; if (start !== 1'b1 || grant !== 4'b0010 || txd !== 8'h71) begin bad++; $display("FAIL to_first_start got=%b/%b/%h exp=1/0010/71", start, grant, txd); end
        step(); step(); step();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL to_still_waiting got=%b exp=0010", grant); end
        step();
        total++; if (grant !== 4'b0000 || start !== 1'b0) begin bad++; $display("FAIL to_abandon got=%b/%b exp=0000/0", grant, start); end
        total++; if (pend !== 4'b0100) begin bad++; $display("FAIL to_pend_clr got=%b exp=0100", pend); end
        total++; if (start_n - base != 1) begin bad++; $display("FAIL to_no_retry got=%0d exp=1", start_n - base); end
        step();
        total++; if (start !== 1'b1 || grant !== 4'b0100 || txd !== 8'h72) begin bad++; $display("FAIL to_next_served got=%b/%b/%h exp=1/0100/72", start, grant, txd); end
        wait_quiet(50);
        total++; if (start_n - base != 2) begin bad++; $display("FAIL to_count got=%0d exp=2", start_n - base); end
        model_en = 1'b1;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset(); base = start_n;
        dat = 32'h5A00_0000; lvl = 4'b1000;
        step(); step();
        total++; if (start !== 1'b1) begin bad++; $display("FAIL rmid_start got=%b exp=1", start); end
        step(); step(); step(); step();
        total++; if (grant !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL rmid_in_frame grant=%b busy=%b exp=1000/1", grant, busy); end
        rst = 1'b1;
        step();
        total++; if (start !== 1'b0 || grant !== 4'b0 || txd !== 8'h00 || pend !== 4'b0) begin bad++; $display("FAIL rmid_cleared got=%b/%b/%h/%b exp=0/0000/00/0000", start, grant, txd, pend); end
`ifdef TX_ARB_OVERRUN_EN
        total++; if (ovr !== 4'b0) begin bad++; $display("FAIL rmid_overrun got=%b exp=0000", ovr); end
`endif
        rst = 1'b0;
        step();
        total++; if (pend !== 4'b1000) begin bad++; $display("FAIL rmid_repost got=%b exp=1000", pend); end
        step();
        total++; if (start !== 1'b1 || grant !== 4'b1000 || txd !== 8'h5A) begin bad++; $display("FAIL rmid_restart got=%b/%b/%h exp=1/1000/5a", start, grant, txd); end
        wait_quiet(100);
        total++; if (start_n - base != 2) begin bad++; $display("FAIL rmid_count got=%0d exp=2", start_n - base); end
        lvl = '0;
        $display("test_reset_mid done");
    endtask

    task automatic test_clear_set();
        int base;
        do_reset(); base = start_n;
        dat = 32'h0021_0000; lvl = 4'b0100;
        step(); lvl = '0;
        step();
        total++; if (start !== 1'b1 || txd !== 8'h21) begin bad++; $display("FAIL cs_start got=%b/%h exp=1/21", start, txd); end
        dat = 32'h0022_0000; lvl = 4'b0100;
        step(); lvl = '0;
        total++; if (pend !== 4'b0100) begin bad++; $display("FAIL cs_set_wins got=%b exp=0100", pend); end
        total++; if (txd !== 8'h21) begin bad++; $display("FAIL cs_data_stable got=%h exp=21", txd); end
`ifdef TX_ARB_OVERRUN_EN
        total++; if (ovr !== 4'b0) begin bad++; $display("FAIL cs_no_overrun got=%b exp=0000", ovr); end
`endif
        wait_quiet(100);
        total++; if (start_n - base != 2) begin bad++; $display("FAIL cs_count got=%0d exp=2", start_n - base); end
        total++; if (log_grant[base+1] !== 4'b0100 || log_data[base+1] !== 8'h22) begin bad++; $display("FAIL cs_second got=%b/%h exp=0100/22", log_grant[base+1], log_data[base+1]); end
        $display("test_clear_set done");
    endtask

    initial begin
        rst = 1'b1; lvl = '0; dat = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_overwrite();
        test_timeout();
        test_reset_mid();
        test_clear_set();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_request_arbiter.md
# tx_request_arbiter

Round-robin scheduler that shares the single UART transmit datapath among `N_REQ` independent requesters. Each requester raises a level; the block detects its low-to-high transition and captures that requester's byte. It then issues a one-cycle start to the transmitter and tracks the transmitter's busy handshake until the frame completes. It sits between the board-level event sources (buttons, status generators) and the UART TX datapath.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width passed to the transmitter.
- `BUSY_TIMEOUT`, 3: cycles to wait in `WAIT_BUSY` for `i_tx_busy` before abandoning the frame (1..15).
- `i_clock`  input  1  single system clock; all logic is on its rising edge.
- `i_reset`  input  1  synchronous, active-high reset.
- `i_req_level`  input  `N_REQ`  request levels; a rising edge posts one request.
- `i_req_data`  input  `N_REQ*DATA_W`  per-requester byte; slice r is `[r*DATA_W +: DATA_W]`.
- `i_tx_busy`  input  1  transmitter busy flag, high while a frame is shifting.
- `o_tx_start`  output  1  one-cycle start strobe to the transmitter.
- `o_tx_data`  output  `DATA_W`  byte for the transmitter; valid from `START` through `WAIT_DONE`.
- `o_grant`  output  `N_REQ`  one-hot owner of the transmitter; zero in `IDLE`.
- `o_pending`  output  `N_REQ`  posted requests not yet started.

## Operation
- **Edge detect**, per requester r:
  - `edge[r] = i_req_level[r] & ~prev[r]`; `prev` is registered every cycle and resets to 0.
  - A level already high when reset releases therefore posts one request.
- **Capture:**
  - On `edge[r]`: `pending[r]` is set and the `i_req_data` slice r is latched into `hold[r]`.
  - An edge while `pending[r]` is already set overwrites `hold[r]`; it does not queue a second request (last data wins).
- **FSM states:** `IDLE`, `START`, `WAIT_BUSY`, `WAIT_DONE`.
  - `IDLE`: if any `pending` bit is set, select the first set bit searching upward from `ptr` with wrap-around. Register the grant and `o_tx_data = hold[sel]`, then go to `START`.
  - `START`: `o_tx_start = 1`. Clear `pending[sel]` on exit. If `edge[sel]` occurs in this same cycle, set wins and the new request stays pending. Go to `WAIT_BUSY` with timeout counter = 0.
  - `WAIT_BUSY`: if `i_tx_busy` = 1, go to `WAIT_DONE`. Else increment the counter; when it reaches `BUSY_TIMEOUT`, go to `IDLE` (frame dropped, not retried).
  - `WAIT_DONE`: when `i_tx_busy` = 0, go to `IDLE`.
  - On every exit to `IDLE`: `ptr = (sel+1) mod N_REQ`.
- **Data stability:** `o_grant` and `o_tx_data` stay constant from `START` until `IDLE` is re-entered. Later edges by the granted requester update only `hold`, never `o_tx_data`.
- **Reset values:**
  - `o_tx_start` = 0, `o_grant` = 0, `o_tx_data` = 0, `o_pending` = 0.
  - `prev` = 0, `hold` = 0, `ptr` = 0, state = `IDLE`.
  - Reset mid-frame abandons the frame immediately; no further strobe is issued.

## Timing
- Rising level sampled at clock edge k: `o_pending[r]` is high after edge k.
- If the FSM is idle, the state is `START` after edge k+1, so `o_tx_start` is high for exactly the cycle between edges k+1 and k+2.
- `o_pending[r]` clears after edge k+2.
- Minimum turnaround from busy falling to the next `o_tx_start`: 2 cycles (`WAIT_DONE` → `IDLE` → `START`).
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Configuration
- **`TX_ARB_OVERRUN_EN`** defined:
  - Adds output `o_overrun`  output  `N_REQ`.
  - `o_overrun[r]` sets when `edge[r]` occurs while `pending[r]` is already set and not being cleared that cycle.
  - It is sticky until `i_reset`.
- **`TX_ARB_OVERRUN_EN`** undefined: the port and its logic are absent. Overwrite behaviour is unchanged.

## Test plan
- **Single request:** reset, then raise `i_req_level[2]` with data 0x41, `i_tx_busy` responding after 1 cycle for 10 cycles → exactly one `o_tx_start`, 2 cycles after the level is sampled. Expect `o_tx_data` = 0x41 and `o_grant` = 0b0100 until busy falls; then `IDLE` with grant 0.
- **Round-robin:** all four levels rise in the same cycle with data 0x10..0x13 → starts in order 0, 1, 2, 3. Then re-raise 0 and 3 → order 0, 3. Then re-raise 0 and 3 again → order 0, 3, since `ptr` wraps past 3 to 0.
- **Overwrite while pending:** requester 1 busy-blocked by requester 0; pulse req 1 with 0x55 then 0x66 → a single frame for req 1 carrying 0x66. `o_overrun[1]` = 1 only when the macro is defined.
- **Busy timeout:** `i_tx_busy` held 0 with `BUSY_TIMEOUT` = 3 → `IDLE` 4 cycles after `START`, `pending` cleared, no second strobe, next requester served.
- **Reset mid-frame:** assert `i_reset` for 1 cycle during `WAIT_DONE` → all outputs 0 the next cycle. A level held high through reset posts one new request after release.
- **Simultaneous clear/set:** edge on the granted requester exactly in the `START` cycle → `o_pending` stays 1 and a second frame follows.
